run_last_seq: RTL and testbench

Parametrised three-phase run sequencer: IDLE → RUN → LAST (tail) → IDLE, driven by a request level. It emits transition-qualified pulses (`g` on RUN exit, `s` on each RUN continuation) and adds a bounded run length with overflow, a programmable tail length, an abort path and optional registered outputs. It sits between a request source and a downstream engine that needs per-cycle continue strobes and an end-of-run strobe with the measured length.

---
 rtl/run_last_seq_pkg.sv | 29 ++
 rtl/run_last_seq_if.sv | 23 ++
 rtl/run_last_seq_seq_pulse_out.sv | 49 ++++
 rtl/run_last_seq.sv | 123 ++++++++++++
 tb/tb_run_last_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/run_last_seq_pkg.sv
// Shared definitions for the run/last sequencer: state encoding and
// parameter legality helpers used at elaboration time.
package run_last_seq_pkg;

    // Sequencer phases. Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    // Smallest legal forced-termination length.
    localparam int MIN_MAX_RUN     = 1;
    // Smallest legal tail length.
    localparam int MIN_LAST_CYCLES = 1;

    // MAX_RUN must be representable in the run counter and be non-zero.
    function automatic bit max_run_ok(input int cnt_w, input int max_run);
        longint lim;
        lim = (longint'(1) << cnt_w) - 1;
        return (max_run >= MIN_MAX_RUN) && (longint'(max_run) <= lim);
    endfunction

    // The tail phase always lasts at least one cycle.
    function automatic bit last_cycles_ok(input int last_cycles);
        return last_cycles >= MIN_LAST_CYCLES;
    endfunction

endpackage

// File: rtl/run_last_seq_if.sv
// Request/strobe bundle between a request source (master) and the
// run sequencer (slave).
interface run_last_seq_if #(
    parameter int CNT_W = 8
) ();
    logic             req;
    logic             abort;
    logic             g;
    logic             s;
    logic             ovf;
    logic [CNT_W-1:0] run_len;
    logic             busy;

    modport master (
        output req, abort,
        input  g, s, ovf, run_len, busy
    );

    modport slave (
        input  req, abort,
        output g, s, ovf, run_len, busy
    );
endinterface

// File: rtl/run_last_seq_seq_pulse_out.sv
// Optional output register stage for the g/s/ovf strobes. With REG_OUT=0
// the strobes pass straight through; with REG_OUT=1 they are delayed by
// one clock and cleared by reset.
module seq_pulse_out #(
    parameter int REG_OUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_g,
    input  logic i_s,
    input  logic i_ovf,
    output logic o_g,
    output logic o_s,
    output logic o_ovf
);

    if (REG_OUT != 0) begin : g_reg
        logic r_g;
        logic r_s;
        logic r_ovf;

        // Delay every strobe by one cycle; abort does not cancel a strobe
        // that was already decided in the previous cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_g   <= 1'b0;
                r_s   <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                r_g   <= i_g;
                r_s   <= i_s;
                r_ovf <= i_ovf;
            end
        end

        assign o_g   = r_g;
        assign o_s   = r_s;
        assign o_ovf = r_ovf;
    end else begin : g_pass
        // Clock and reset have no load in the combinational variant.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst_n;

        assign o_g   = i_g;
        assign o_s   = i_s;
        assign o_ovf = i_ovf;
    end

endmodule

// File: rtl/run_last_seq.sv
// Three-phase run sequencer: IDLE -> RUN -> LAST (tail) -> IDLE.
// Emits a continue strobe (s) on every RUN cycle that stays in RUN, an
// end-of-run strobe (g) when RUN is left normally, and ovf with g when
// the run was cut at MAX_RUN cycles. run_len holds the measured length
// of the most recent completed run.
module run_last_seq
    import run_last_seq_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int MAX_RUN     = 255,
    parameter int LAST_CYCLES = 1,
    parameter int REG_OUT     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    run_last_seq_if.slave bus
);

    // Tail counter only needs to hold LAST_CYCLES-1 down to 0.
    localparam int               TAIL_W    = $clog2(LAST_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TAIL_W-1:0] TAIL_INIT = TAIL_W'(LAST_CYCLES - 1);
    localparam logic [TAIL_W-1:0] TAIL_ONE  = TAIL_W'(1);

    if (!max_run_ok(CNT_W, MAX_RUN) || !last_cycles_ok(LAST_CYCLES)) begin : g_param_err
        $error("run_last_seq: MAX_RUN must be 1..2^CNT_W-1 and LAST_CYCLES >= 1");
    end

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_run_len;
    logic [TAIL_W-1:0]   r_tail;

    logic                w_g;
    logic                w_s;
    logic                w_ovf;
    logic                w_g_out;
    logic                w_s_out;
    logic                w_ovf_out;

    // Decide this cycle's strobes from the current state and inputs
    // (abort beats end-of-request, which beats the MAX_RUN cut).
    always_comb begin
        w_g   = 1'b0;
        w_s   = 1'b0;
        w_ovf = 1'b0;
        if (r_state == ST_RUN && !bus.abort) begin
            if (!bus.req) begin
                w_g = 1'b1;
            end else if (r_cnt == MAX_RUN_C) begin
                w_g   = 1'b1;
                w_ovf = 1'b1;
            end else begin
                w_s = 1'b1;
            end
        end
    end

    // Phase register plus run counter, tail counter and captured length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tail    <= '0;
            r_run_len <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_state <= ST_RUN;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (!bus.req) begin
                        r_state   <= ST_LAST;
                        r_run_len <= r_cnt;
                        r_tail    <= TAIL_INIT;
                    end else if (r_cnt == MAX_RUN_C) begin
                        r_state   <= ST_LAST;
                        r_run_len <= MAX_RUN_C;
                        r_tail    <= TAIL_INIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_LAST: begin
                    if (bus.abort || r_tail == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tail <= r_tail - TAIL_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    seq_pulse_out #(
        .REG_OUT (REG_OUT)
    ) u_pulse_out (
        .clk   (clk),
        .rst_n (rst_n),
        .i_g   (w_g),
        .i_s   (w_s),
        .i_ovf (w_ovf),
        .o_g   (w_g_out),
        .o_s   (w_s_out),
        .o_ovf (w_ovf_out)
    );

    assign bus.g       = w_g_out;
    assign bus.s       = w_s_out;
    assign bus.ovf     = w_ovf_out;
    assign bus.run_len = r_run_len;
    assign bus.busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_run_last_seq.sv
// Bench for run_last_seq: three parameterisations driven by a shared
// request stream; expected strobes come from a run/tail model and are
// queued per cycle, a separate monitor pops and compares.
module tb_run_last_seq;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic abort;

    always #5 clk = ~clk;

    run_last_seq_if #(.CNT_W(8)) if_a ();
    run_last_seq_if #(.CNT_W(3)) if_b ();
    run_last_seq_if #(.CNT_W(8)) if_c ();

    assign if_a.req = req;  assign if_a.abort = abort;
    assign if_b.req = req;  assign if_b.abort = abort;
    assign if_c.req = req;  assign if_c.abort = abort;

    run_last_seq #(.CNT_W(8), .MAX_RUN(5), .LAST_CYCLES(1), .REG_OUT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    run_last_seq #(.CNT_W(3), .MAX_RUN(4), .LAST_CYCLES(3), .REG_OUT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    run_last_seq dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c));

    function automatic int p_max(input int i);
        case (i) 0: return 5; 1: return 4; default: return 255; endcase
    endfunction
    function automatic int p_last(input int i);
        case (i) 1: return 3; default: return 1; endcase
    endfunction
    function automatic bit p_reg(input int i);
        return (i == 1);
    endfunction

    typedef struct packed {
        logic       g;
        logic       s;
        logic       ovf;
        logic       busy;
        logic [7:0] len;
    } exp_one_t;
    typedef exp_one_t [N-1:0] exp_all_t;

    exp_all_t sb_q[$];

    // Model: phase 0 waiting, 1 running (run_cycles counted so far),
    // 2 tail (tail_left cycles still to spend); last_len is the reported length.
    int phase[N];
    int run_cycles[N];
    int tail_left[N];
    int last_len[N];
    bit dly_g[N];
    bit dly_s[N];
    bit dly_o[N];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    task automatic model_cycle(input bit rn, input bit rq, input bit ab, output exp_all_t e);
        bit cg, cs, co;
        for (int i = 0; i < N; i++) begin
            if (!rn) begin
                phase[i] = 0; run_cycles[i] = 0; tail_left[i] = 0; last_len[i] = 0;
                dly_g[i] = 0; dly_s[i] = 0; dly_o[i] = 0;
                e[i] = '0;
            end else begin
                cg = 0; cs = 0; co = 0;
                if (phase[i] == 1 && !ab) begin
                    if (!rq) cg = 1;
                    else if (run_cycles[i] >= p_max(i)) begin cg = 1; co = 1; end
                    else cs = 1;
                end
                e[i].g    = p_reg(i) ? dly_g[i] : cg;
                e[i].s    = p_reg(i) ? dly_s[i] : cs;
                e[i].ovf  = p_reg(i) ? dly_o[i] : co;
                e[i].busy = (phase[i] != 0);
                e[i].len  = 8'(last_len[i]);
                dly_g[i] = cg; dly_s[i] = cs; dly_o[i] = co;
                if (phase[i] == 0) begin
                    if (rq) begin phase[i] = 1; run_cycles[i] = 1; end
                end else if (phase[i] == 1) begin
                    if (ab) phase[i] = 0;
                    else if (cg) begin
                        phase[i] = 2; last_len[i] = run_cycles[i]; tail_left[i] = p_last(i);
                    end else run_cycles[i]++;
                end else begin
                    tail_left[i]--;
                    if (ab || tail_left[i] == 0) phase[i] = 0;
                end
            end
        end
    endtask

    task automatic drive(input bit rn, input bit rq, input bit ab);
        exp_all_t e;
        @(negedge clk);
        rst_n = rn; req = rq; abort = ab;
        model_cycle(rn, rq, ab, e);
        sb_q.push_back(e);
    endtask

    task automatic drive_n(input int n, input bit rn, input bit rq, input bit ab);
        for (int k = 0; k < n; k++) drive(rn, rq, ab);
    endtask

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // Monitor: sample well away from the rising edge and score against the queue.
    initial begin : monitor
        exp_all_t e;
        exp_all_t a;
        while (!done) begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a[0] = '{g: if_a.g, s: if_a.s, ovf: if_a.ovf, busy: if_a.busy, len: if_a.run_len};
                a[1] = '{g: if_b.g, s: if_b.s, ovf: if_b.ovf, busy: if_b.busy, len: {5'b0, if_b.run_len}};
                a[2] = '{g: if_c.g, s: if_c.s, ovf: if_c.ovf, busy: if_c.busy, len: if_c.run_len};
                for (int i = 0; i < N; i++) begin
                    chk("g",       i, {7'b0, a[i].g},    {7'b0, e[i].g});
                    chk("s",       i, {7'b0, a[i].s},    {7'b0, e[i].s});
                    chk("ovf",     i, {7'b0, a[i].ovf},  {7'b0, e[i].ovf});
                    chk("busy",    i, {7'b0, a[i].busy}, {7'b0, e[i].busy});
                    chk("run_len", i, a[i].len,          e[i].len);
                end
                cyc++;
            end
        end
    end

    initial begin : stimulus
        bit rq;
        rst_n = 1'b0; req = 1'b0; abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            phase[i] = 0; run_cycles[i] = 0; tail_left[i] = 0; last_len[i] = 0;
            dly_g[i] = 0; dly_s[i] = 0; dly_o[i] = 0;
        end
        // Reset state, idle, abort while idle.
        drive_n(3, 0, 0, 0);
        drive_n(2, 1, 0, 0);
        drive(1, 0, 1);
        // Three-cycle request.
        drive_n(3, 1, 1, 0);
        drive_n(6, 1, 0, 0);
        // Request held: MAX_RUN cut and re-entry.
        drive_n(20, 1, 1, 0);
        drive_n(6, 1, 0, 0);
        // Abort on second RUN cycle.
        drive_n(2, 1, 1, 0);
        drive(1, 1, 1);
        drive_n(3, 1, 0, 0);
        // Abort in LAST.
        drive_n(3, 1, 1, 0);
        drive(1, 0, 0);
        drive(1, 0, 1);
        drive_n(3, 1, 0, 0);
        // Request toggled during LAST.
        drive_n(2, 1, 1, 0);
        drive(1, 0, 0);
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(1, 1, 0);
        drive_n(6, 1, 0, 0);
        // Reset mid-run, then clean restart.
        drive_n(3, 1, 1, 0);
        drive_n(2, 0, 1, 0);
        drive_n(2, 1, 0, 0);
        drive_n(3, 1, 1, 0);
        drive_n(6, 1, 0, 0);
        // Long hold to reach the default MAX_RUN of 255.
        drive_n(270, 1, 1, 0);
        drive_n(4, 1, 0, 0);
        // Randomised traffic.
        rq = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) rq = ~rq;
            drive($urandom_range(0, 299) != 0, rq, $urandom_range(0, 23) == 0);
        end
        drive_n(2, 1, 0, 0);
        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
